io_request_arbiter: RTL and testbench

IO_REQUEST_ARBITER -- requirements
Module: io_request_arbiter

---
 rtl/io_request_arbiter.sv | 170 +++++++++++++++++
 tb/tb_io_request_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_request_arbiter.sv
// io_request_arbiter
//
// Shares one host line-transfer port between three requesters: an instruction
// fetch unit, a data cache (read fill / writeback) and an accelerator that
// streams ACCEL_LINES consecutive 64-byte lines. Each transaction moves one line.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   common_data_bus_in        read line returned by the host
//   tx_done                   host finished the transfer (honoured in RD / WR)
//   rd_valid                  host committed read data (honoured in RD_WAIT)
//   op                        00 none, 01 read, 11 write
//   io_addr                   64-byte aligned line address of the transaction
//   common_data_bus_out       write line, zero unless op = 11
//   instr_*                   instruction read requester
//   data_*                    data requester (writeback beats fill)
//   accel_*                   accelerator burst requester, one line per grant
//   rd_line                   last read line captured, shared by all requesters
//
// Requests are levels held until the matching done pulse. Done pulses are
// issued in the final cycle of a transaction (RD_WAIT with rd_valid, or
// WR_DONE) so the requester can drop its request before the arbiter is
// back in IDLE and never sees a stale level.

module io_request_arbiter #(
  parameter int ACCEL_LINES = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] common_data_bus_in,
  input  logic         tx_done,
  input  logic         rd_valid,
  output logic [1:0]   op,
  output logic [31:0]  io_addr,
  output logic [511:0] common_data_bus_out,
  input  logic         instr_req,
  input  logic [31:0]  instr_addr,
  output logic         instr_done,
  input  logic         data_rd_req,
  input  logic         data_wr_req,
  input  logic [31:0]  data_addr,
  input  logic [511:0] data_wr_line,
  output logic         data_done,
  input  logic         accel_rd_req,
  input  logic         accel_wr_req,
  input  logic [31:0]  accel_base,
  input  logic [511:0] accel_wr_line,
  output logic [6:0]   accel_line_idx,
  output logic         accel_line_done,
  output logic         accel_done,
  output logic [511:0] rd_line
);

  localparam logic [6:0] LAST_IDX = 7'(ACCEL_LINES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_WR_DONE} state_t;
  typedef enum logic [1:0] {OWN_INSTR, OWN_DATA, OWN_ACCEL} owner_t;

  state_t        state_reg, state_next;
  owner_t        owner_reg, owner_next;
  logic [31:0]   addr_reg, addr_next;
  logic [511:0]  wline_reg, wline_next;
  logic [511:0]  rd_line_reg;
  logic [6:0]    idx_reg;
  logic          line_done;
  logic          done_fire;
  logic [31:0]   accel_addr;
  logic          unused_addr_bits;

  // Byte offsets within a line are not part of the line address.
  assign unused_addr_bits = ^{instr_addr[5:0], data_addr[5:0], accel_base[5:0]};

  // Burst line address: aligned base plus idx lines, wrapping modulo 2^32.
  assign accel_addr = {accel_base[31:6], 6'b0} + {19'b0, idx_reg, 6'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      owner_reg   <= OWN_INSTR;
      addr_reg    <= '0;
      wline_reg   <= '0;
      rd_line_reg <= '0;
      idx_reg     <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      wline_reg <= wline_next;
      if (state_reg == S_RD && tx_done) begin
        rd_line_reg <= common_data_bus_in;
      end
      if (accel_line_done) begin
        idx_reg <= (idx_reg == LAST_IDX) ? 7'd0 : idx_reg + 7'd1;
      end
    end
  end

  // Next-state logic. Address and write line are latched at grant so they
  // stay stable for the whole transaction even if the requester changes them.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    wline_next = wline_reg;
    line_done  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (data_wr_req) begin
          owner_next = OWN_DATA;
          addr_next  = {data_addr[31:6], 6'b0};
          wline_next = data_wr_line;
          state_next = S_WR;
        end else if (data_rd_req) begin
          owner_next = OWN_DATA;
          addr_next  = {data_addr[31:6], 6'b0};
          state_next = S_RD;
        end else if (instr_req) begin
          owner_next = OWN_INSTR;
          addr_next  = {instr_addr[31:6], 6'b0};
          state_next = S_RD;
        end else if (accel_rd_req) begin
          owner_next = OWN_ACCEL;
          addr_next  = accel_addr;
          state_next = S_RD;
        end else if (accel_wr_req) begin
          owner_next = OWN_ACCEL;
          addr_next  = accel_addr;
          wline_next = accel_wr_line;
          state_next = S_WR;
        end
      end
      S_RD: begin
        if (tx_done) state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_valid) begin
          line_done  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WR: begin
        if (tx_done) state_next = S_WR_DONE;
      end
      S_WR_DONE: begin
        line_done  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    op = 2'b00;
    if (state_reg == S_RD) op = 2'b01;
    else if (state_reg == S_WR) op = 2'b11;
  end

  // A transaction cut short by reset must not report completion.
  assign done_fire           = line_done & ~rst;
  assign instr_done          = done_fire && (owner_reg == OWN_INSTR);
  assign data_done           = done_fire && (owner_reg == OWN_DATA);
  assign accel_line_done     = done_fire && (owner_reg == OWN_ACCEL);
  assign accel_done          = accel_line_done && (idx_reg == LAST_IDX);

  assign io_addr             = addr_reg;
  assign common_data_bus_out = (state_reg == S_WR) ? wline_reg : 512'b0;
  assign rd_line             = rd_line_reg;
  assign accel_line_idx      = idx_reg;

endmodule

// File: tb/tb_io_request_arbiter.sv
module tb_io_request_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] common_data_bus_in;
  logic         tx_done, rd_valid;
  logic [1:0]   op;
  logic [31:0]  io_addr;
  logic [511:0] common_data_bus_out;
  logic         instr_req;
  logic [31:0]  instr_addr;
  logic         instr_done;
  logic         data_rd_req, data_wr_req;
  logic [31:0]  data_addr;
  logic [511:0] data_wr_line;
  logic         data_done;
  logic         accel_rd_req, accel_wr_req;
  logic [31:0]  accel_base;
  logic [511:0] accel_wr_line;
  logic [6:0]   accel_line_idx;
  logic         accel_line_done, accel_done;
  logic [511:0] rd_line;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_instr = 0, cnt_data = 0, cnt_line = 0, cnt_adone = 0;
  logic [1:0] last_op = 2'b00;

  localparam logic [511:0] PAT_A = {16{32'hA5A5_0001}};
  localparam logic [511:0] PAT_B = {16{32'hB0B0_0002}};
  localparam logic [511:0] PAT_C = {16{32'hC3C3_0003}};
  localparam logic [511:0] PAT_D = {16{32'h0DA7_A000}};

  always #5 clk = ~clk;

  io_request_arbiter #(.ACCEL_LINES(128)) dut (
    .clk(clk), .rst(rst),
    .common_data_bus_in(common_data_bus_in), .tx_done(tx_done), .rd_valid(rd_valid),
    .op(op), .io_addr(io_addr), .common_data_bus_out(common_data_bus_out),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_done(instr_done),
    .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_addr(data_addr),
    .data_wr_line(data_wr_line), .data_done(data_done),
    .accel_rd_req(accel_rd_req), .accel_wr_req(accel_wr_req), .accel_base(accel_base),
    .accel_wr_line(accel_wr_line), .accel_line_idx(accel_line_idx),
    .accel_line_done(accel_line_done), .accel_done(accel_done),
    .rd_line(rd_line)
  );

  // One clock: observe done pulses for the inputs driven this cycle, let the
  // requesters drop their levels on done, then advance to the next negedge.
  task automatic cycle();
    #1;
    if (op != 2'b00) last_op = op;
    if (instr_done) begin
      cnt_instr++;
      instr_req = 1'b0;
      $display("txn: instr  done addr=%h", io_addr);
    end
    if (data_done) begin
      cnt_data++;
      if (last_op == 2'b11) data_wr_req = 1'b0;
      else data_rd_req = 1'b0;
      $display("txn: data   done addr=%h op=%b", io_addr, last_op);
    end
    if (accel_line_done) begin
      cnt_line++;
      $display("txn: accel  line idx=%0d addr=%h op=%b burst_end=%b", accel_line_idx, io_addr, last_op, accel_done);
    end
    if (accel_done) begin
      cnt_adone++;
      accel_rd_req = 1'b0;
      accel_wr_req = 1'b0;
    end
    @(negedge clk);
  endtask

  // Host side of one transaction: wait for a grant, hold off lat cycles,
  // finish with tx_done (+ rd_valid for reads). Reports what the DUT drove.
  task automatic serve(input int lat, input logic [511:0] line, input bit stray,
                       input bit raise_instr, output logic [1:0] o_op,
                       output logic [31:0] o_addr, output logic [511:0] o_bus,
                       output bit o_stable);
    int guard;
    guard = 0;
    while (op == 2'b00 && guard < 20) begin
      cycle();
      guard++;
    end
    o_op = op;
    o_addr = io_addr;
    o_bus = common_data_bus_out;
    o_stable = 1'b1;
    if (op == 2'b00) return;
    if (raise_instr) begin
      instr_req = 1'b1;
      instr_addr = 32'h2000_0099;
    end
    for (int k = 0; k < lat; k++) begin
      if (stray) rd_valid = 1'b1;
      cycle();
      rd_valid = 1'b0;
      if (op !== o_op || io_addr !== o_addr || common_data_bus_out !== o_bus) o_stable = 1'b0;
    end
    tx_done = 1'b1;
    common_data_bus_in = line;
    cycle();
    tx_done = 1'b0;
    if (o_op == 2'b01) begin
      rd_valid = 1'b1;
      cycle();
      rd_valid = 1'b0;
    end else begin
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    n_cmp++; if (op !== 2'b00) begin n_err++; $display("FAIL reset_op: got %b want 00", op); end
    n_cmp++; if (io_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", io_addr); end
    n_cmp++; if (common_data_bus_out !== 512'h0) begin n_err++; $display("FAIL reset_bus_out: got nonzero want 0"); end
    n_cmp++; if (rd_line !== 512'h0) begin n_err++; $display("FAIL reset_rd_line: got nonzero want 0"); end
    n_cmp++; if (accel_line_idx !== 7'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", accel_line_idx); end
    n_cmp++;
    if ({instr_done, data_done, accel_line_done, accel_done} !== 4'b0) begin
      n_err++; $display("FAIL reset_dones: got %b want 0000", {instr_done, data_done, accel_line_done, accel_done});
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_instr_read();
    int base;
    base = cnt_instr;
    instr_req = 1'b1;
    instr_addr = 32'h0000_0044;
    cycle();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (op !== 2'b01 || io_addr !== 32'h0000_0040 || common_data_bus_out !== 512'h0) begin
        n_err++; $display("FAIL instr_rd_phase c%0d: got op=%b addr=%h want op=01 addr=00000040", i, op, io_addr);
      end
      cycle();
    end
    tx_done = 1'b1;
    common_data_bus_in = PAT_A;
    cycle();
    tx_done = 1'b0;
    common_data_bus_in = '0;
    n_cmp++; if (op !== 2'b00) begin n_err++; $display("FAIL instr_rd_wait_op: got %b want 00", op); end
    n_cmp++; if (rd_line !== PAT_A) begin n_err++; $display("FAIL instr_rd_line: got %h want %h", rd_line[31:0], PAT_A[31:0]); end
    n_cmp++; if (cnt_instr != base) begin n_err++; $display("FAIL instr_early_done: got %0d want 0", cnt_instr - base); end
    rd_valid = 1'b1;
    cycle();
    rd_valid = 1'b0;
    cycle();
    cycle();
    n_cmp++; if (cnt_instr != base + 1) begin n_err++; $display("FAIL instr_done_count: got %0d want 1", cnt_instr - base); end
    n_cmp++; if (op !== 2'b00) begin n_err++; $display("FAIL instr_after_op: got %b want 00", op); end
  endtask

  task automatic test_idle_ignore();
    tx_done = 1'b1;
    rd_valid = 1'b1;
    common_data_bus_in = PAT_C;
    cycle();
    cycle();
    tx_done = 1'b0;
    rd_valid = 1'b0;
    common_data_bus_in = '0;
    n_cmp++; if (op !== 2'b00) begin n_err++; $display("FAIL idle_op: got %b want 00", op); end
    n_cmp++; if (rd_line !== PAT_A) begin n_err++; $display("FAIL idle_rd_line: got %h want %h", rd_line[31:0], PAT_A[31:0]); end
  endtask

  task automatic test_priority();
    logic [1:0] o_op; logic [31:0] o_addr; logic [511:0] o_bus; bit o_st;
    int bi, bd;
    bi = cnt_instr;
    bd = cnt_data;
    data_wr_req = 1'b1; data_rd_req = 1'b1; instr_req = 1'b1;
    data_addr = 32'h3000_0000; data_wr_line = PAT_B; instr_addr = 32'h1234_5678;
    serve(2, '0, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
    n_cmp++;
    if (o_op !== 2'b11 || o_addr !== 32'h3000_0000 || o_bus !== PAT_B || !o_st) begin
      n_err++; $display("FAIL prio_first_wr: got op=%b addr=%h bus=%h stable=%0d want op=11 addr=30000000 bus=%h", o_op, o_addr, o_bus[31:0], o_st, PAT_B[31:0]);
    end
    n_cmp++;
    if (cnt_data != bd + 1 || cnt_instr != bi) begin
      n_err++; $display("FAIL prio_first_done: got data=%0d instr=%0d want 1/0", cnt_data - bd, cnt_instr - bi);
    end
    serve(1, PAT_D, 1'b1, 1'b0, o_op, o_addr, o_bus, o_st);
    n_cmp++;
    if (o_op !== 2'b01 || o_addr !== 32'h3000_0000 || o_bus !== 512'h0 || !o_st) begin
      n_err++; $display("FAIL prio_second_rd: got op=%b addr=%h stable=%0d want op=01 addr=30000000", o_op, o_addr, o_st);
    end
    n_cmp++; if (rd_line !== PAT_D) begin n_err++; $display("FAIL prio_rd_line: got %h want %h", rd_line[31:0], PAT_D[31:0]); end
    serve(0, PAT_A, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
    n_cmp++;
    if (o_op !== 2'b01 || o_addr !== 32'h1234_5640) begin
      n_err++; $display("FAIL prio_third_instr: got op=%b addr=%h want op=01 addr=12345640", o_op, o_addr);
    end
    cycle();
    cycle();
    n_cmp++;
    if (cnt_data != bd + 2 || cnt_instr != bi + 1 || op !== 2'b00) begin
      n_err++; $display("FAIL prio_totals: got data=%0d instr=%0d op=%b want 2/1/00", cnt_data - bd, cnt_instr - bi, op);
    end
  endtask

  task automatic test_drop();
    logic [1:0] o_op; logic [31:0] o_addr; logic [511:0] o_bus; bit o_st;
    int bi;
    bi = cnt_instr;
    data_rd_req = 1'b1;
    data_addr = 32'h0000_1080;
    cycle();
    instr_req = 1'b1;
    instr_addr = 32'h0000_2000;
    cycle();
    instr_req = 1'b0;
    serve(1, PAT_B, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
    cycle();
    cycle();
    n_cmp++;
    if (op !== 2'b00 || cnt_instr != bi) begin
      n_err++; $display("FAIL drop_before_grant: got op=%b instr=%0d want 00/0", op, cnt_instr - bi);
    end
    instr_req = 1'b1;
    instr_addr = 32'h0000_3004;
    cycle();
    instr_req = 1'b0;
    serve(0, PAT_C, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
    n_cmp++;
    if (o_op !== 2'b01 || o_addr !== 32'h0000_3000 || cnt_instr != bi + 1) begin
      n_err++; $display("FAIL drop_after_grant: got op=%b addr=%h instr=%0d want 01/00003000/1", o_op, o_addr, cnt_instr - bi);
    end
  endtask

  task automatic test_accel_read();
    logic [1:0] o_op; logic [31:0] o_addr; logic [511:0] o_bus; bit o_st;
    int bl, ba, bi;
    logic [31:0] want;
    bl = cnt_line;
    ba = cnt_adone;
    accel_base = 32'h1000_0000;
    accel_rd_req = 1'b1;
    for (int i = 0; i < 128; i++) begin
      want = 32'h1000_0000 + 32'(i * 64);
      serve(0, {16{32'(i)}}, 1'b0, (i == 5), o_op, o_addr, o_bus, o_st);
      n_cmp++;
      if (o_op !== 2'b01 || o_addr !== want || o_bus !== 512'h0 || !o_st) begin
        n_err++; $display("FAIL accel_rd_line%0d: got op=%b addr=%h want op=01 addr=%h", i, o_op, o_addr, want);
      end
      n_cmp++;
      if (cnt_adone - ba != ((i == 127) ? 1 : 0)) begin
        n_err++; $display("FAIL accel_rd_done_line%0d: got %0d want %0d", i, cnt_adone - ba, (i == 127) ? 1 : 0);
      end
      if (i == 5) begin
        bi = cnt_instr;
        serve(0, PAT_A, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
        n_cmp++;
        if (o_op !== 2'b01 || o_addr !== 32'h2000_0080 || cnt_instr != bi + 1) begin
          n_err++; $display("FAIL accel_preempt_instr: got op=%b addr=%h done=%0d want 01/20000080/1", o_op, o_addr, cnt_instr - bi);
        end
        n_cmp++;
        if (accel_line_idx !== 7'd6) begin
          n_err++; $display("FAIL accel_preempt_idx: got %0d want 6", accel_line_idx);
        end
      end
    end
    cycle();
    cycle();
    n_cmp++;
    if (cnt_line - bl != 128 || accel_line_idx !== 7'd0 || op !== 2'b00) begin
      n_err++; $display("FAIL accel_rd_end: got lines=%0d idx=%0d op=%b want 128/0/00", cnt_line - bl, accel_line_idx, op);
    end
    n_cmp++; if (rd_line !== {16{32'd127}}) begin n_err++; $display("FAIL accel_rd_last_line: got %h want 0000007f", rd_line[31:0]); end
  endtask

  task automatic test_accel_write();
    logic [1:0] o_op; logic [31:0] o_addr; logic [511:0] o_bus; bit o_st;
    int bl, ba;
    logic [31:0] want;
    logic [511:0] wl;
    bl = cnt_line;
    ba = cnt_adone;
    accel_base = 32'h4000_0025;
    accel_wr_req = 1'b1;
    for (int i = 0; i < 128; i++) begin
      want = 32'h4000_0000 + 32'(i * 64);
      wl = PAT_C ^ {16{32'(i)}};
      accel_wr_line = wl;
      serve(2, '0, 1'b1, 1'b0, o_op, o_addr, o_bus, o_st);
      n_cmp++;
      if (o_op !== 2'b11 || o_addr !== want || o_bus !== wl || !o_st) begin
        n_err++; $display("FAIL accel_wr_line%0d: got op=%b addr=%h bus=%h stable=%0d want op=11 addr=%h bus=%h", i, o_op, o_addr, o_bus[31:0], o_st, want, wl[31:0]);
      end
    end
    cycle();
    cycle();
    n_cmp++;
    if (cnt_line - bl != 128 || cnt_adone - ba != 1 || accel_line_idx !== 7'd0) begin
      n_err++; $display("FAIL accel_wr_end: got lines=%0d bursts=%0d idx=%0d want 128/1/0", cnt_line - bl, cnt_adone - ba, accel_line_idx);
    end
    n_cmp++;
    if (rd_line !== {16{32'd127}} || common_data_bus_out !== 512'h0) begin
      n_err++; $display("FAIL accel_wr_side: got rd_line=%h bus_out=%h want 0000007f/0", rd_line[31:0], common_data_bus_out[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] o_op; logic [31:0] o_addr; logic [511:0] o_bus; bit o_st;
    int bl;
    accel_base = 32'h1000_0000;
    accel_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) serve(0, PAT_B, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
    cycle();
    n_cmp++;
    if (op !== 2'b01 || io_addr !== 32'h1000_00C0) begin
      n_err++; $display("FAIL rstmid_line3: got op=%b addr=%h want 01/100000c0", op, io_addr);
    end
    tx_done = 1'b1;
    cycle();
    tx_done = 1'b0;
    bl = cnt_line;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    accel_rd_req = 1'b0;
    n_cmp++;
    if (op !== 2'b00 || accel_line_idx !== 7'd0 || cnt_line != bl) begin
      n_err++; $display("FAIL rstmid_after: got op=%b idx=%0d dones=%0d want 00/0/0", op, accel_line_idx, cnt_line - bl);
    end
    rd_valid = 1'b1;
    cycle();
    rd_valid = 1'b0;
    cycle();
    n_cmp++;
    if (op !== 2'b00 || cnt_line != bl || accel_line_idx !== 7'd0) begin
      n_err++; $display("FAIL rstmid_stray_rd_valid: got op=%b dones=%0d idx=%0d want 00/0/0", op, cnt_line - bl, accel_line_idx);
    end
    accel_rd_req = 1'b1;
    serve(0, PAT_C, 1'b0, 1'b0, o_op, o_addr, o_bus, o_st);
    accel_rd_req = 1'b0;
    n_cmp++;
    if (o_op !== 2'b01 || o_addr !== 32'h1000_0000 || accel_line_idx !== 7'd1) begin
      n_err++; $display("FAIL rstmid_restart: got op=%b addr=%h idx=%0d want 01/10000000/1", o_op, o_addr, accel_line_idx);
    end
  endtask

  initial begin
    rst = 1'b1;
    common_data_bus_in = '0; tx_done = 1'b0; rd_valid = 1'b0;
    instr_req = 1'b0; instr_addr = '0;
    data_rd_req = 1'b0; data_wr_req = 1'b0; data_addr = '0; data_wr_line = '0;
    accel_rd_req = 1'b0; accel_wr_req = 1'b0; accel_base = '0; accel_wr_line = '0;
    @(negedge clk);
    test_reset();
    test_instr_read();
    test_idle_ignore();
    test_priority();
    test_drop();
    test_accel_read();
    test_accel_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
